// File: rtl/vga_sprite_overlay.sv
// Single 16x16 1bpp sprite compositor on an RGB222 video stream, with a double-buffered position and a frame IRQ.
// Define SPRITE_COLLISION_EN to build sticky sprite/background collision detection (STATUS.COLL, CTRL.coll_irq_en).
module vga_sprite_overlay #(
    parameter int SPR_SIZE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  reg_addr,
    input  logic [15:0] reg_wdata,
    input  logic        reg_we,
    output logic [15:0] reg_rdata,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic        visible,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [5:0]  bg_rgb_in,
    output logic [5:0]  rgb_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        irq
);

    localparam int SPR_BITS = $clog2(SPR_SIZE);

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_X      = 6'h04;
    localparam logic [5:0] ADDR_Y      = 6'h08;
    localparam logic [5:0] ADDR_COLOR  = 6'h0C;
    localparam logic [5:0] ADDR_STATUS = 6'h10;
    localparam logic [5:0] ADDR_FCNT   = 6'h14;

    logic        sprite_en;
    logic        frame_irq_en;
    logic        coll_irq_en;
    logic [10:0] x_shadow, y_shadow;
    logic [10:0] x_act, y_act;
    logic [5:0]  color;
    logic        st_frame;
    logic        st_coll;
    logic [15:0] frame_cnt;
    logic [15:0] bitmap [SPR_SIZE];
    logic        vsync_q;

    logic        vs_rise;
    logic        bm_sel;
    logic [10:0] dx, dy;
    logic        hit;
    logic [15:0] row_bits;
    logic        opaque;

    assign vs_rise = vsync_in & ~vsync_q;
    // Bitmap rows live at even addresses 0x20..0x3E; row index is addr[4:1].
    assign bm_sel  = reg_addr[5] & ~reg_addr[0];

    // Modular subtraction: pixels left of / above the sprite wrap to large values and miss.
    assign dx       = pix_x - x_act;
    assign dy       = pix_y - y_act;
    assign hit      = (dx[10:SPR_BITS] == '0) && (dy[10:SPR_BITS] == '0);
    assign row_bits = bitmap[dy[SPR_BITS-1:0]];
    assign opaque   = sprite_en & visible & hit & row_bits[~dx[SPR_BITS-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sprite_en    <= 1'b0;
            frame_irq_en <= 1'b0;
            x_shadow     <= '0;
            y_shadow     <= '0;
            x_act        <= '0;
            y_act        <= '0;
            color        <= '0;
            frame_cnt    <= '0;
            vsync_q      <= 1'b0;
            // NOTE: the bitmap is reset explicitly, so it must stay in flops rather than map onto a RAM macro.
            for (int r = 0; r < SPR_SIZE; r++) bitmap[r] <= '0;
        end else begin
            vsync_q <= vsync_in;
            if (reg_we) begin
                case (reg_addr)
                    ADDR_CTRL: begin
                        sprite_en    <= reg_wdata[0];
                        frame_irq_en <= reg_wdata[1];
                    end
                    ADDR_X:     x_shadow <= reg_wdata[10:0];
                    ADDR_Y:     y_shadow <= reg_wdata[10:0];
                    ADDR_COLOR: color    <= reg_wdata[5:0];
                    default: begin
                        if (bm_sel) bitmap[reg_addr[4:1]] <= reg_wdata;
                    end
                endcase
            end
            if (vs_rise) begin
                x_act     <= x_shadow;
                y_act     <= y_shadow;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Status bits: W1C first, set second, so a coincident set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_frame <= 1'b0;
        end else begin
            if (reg_we && reg_addr == ADDR_STATUS && reg_wdata[0]) st_frame <= 1'b0;
            if (vs_rise) st_frame <= 1'b1;
        end
    end

`ifdef SPRITE_COLLISION_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_coll     <= 1'b0;
            coll_irq_en <= 1'b0;
        end else begin
            if (reg_we && reg_addr == ADDR_CTRL) coll_irq_en <= reg_wdata[2];
            if (reg_we && reg_addr == ADDR_STATUS && reg_wdata[1]) st_coll <= 1'b0;
            if (opaque && bg_rgb_in != 6'd0) st_coll <= 1'b1;
        end
    end
`else
    assign st_coll     = 1'b0;
    assign coll_irq_en = 1'b0;
`endif

    assign irq = (st_frame & frame_irq_en) | (st_coll & coll_irq_en);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            ADDR_CTRL:   reg_rdata = {13'd0, coll_irq_en, frame_irq_en, sprite_en};
            ADDR_X:      reg_rdata = {5'd0, x_shadow};
            ADDR_Y:      reg_rdata = {5'd0, y_shadow};
            ADDR_COLOR:  reg_rdata = {10'd0, color};
            ADDR_STATUS: reg_rdata = {14'd0, st_coll, st_frame};
            ADDR_FCNT:   reg_rdata = frame_cnt;
            default: begin
                if (bm_sel) reg_rdata = bitmap[reg_addr[4:1]];
            end
        endcase
    end

    // Single output stage keeps syncs aligned with the composited pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_out   <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
            if (!visible)    rgb_out <= '0;
            else if (opaque) rgb_out <= color;
            else             rgb_out <= bg_rgb_in;
        end
    end

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Scoreboard bench for vga_sprite_overlay: directed stimulus queues expectations, a negedge monitor compares them.
module tb_vga_sprite_overlay;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  reg_addr = '0;
    logic [15:0] reg_wdata = '0;
    logic        reg_we = 1'b0;
    logic [15:0] reg_rdata;
    logic [10:0] pix_x = '0, pix_y = '0;
    logic        visible = 1'b0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0;
    logic [5:0]  bg_rgb_in = '0;
    logic [5:0]  rgb_out;
    logic        hsync_out, vsync_out, irq;

    vga_sprite_overlay #(.SPR_SIZE(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata),
        .pix_x(pix_x), .pix_y(pix_y), .visible(visible),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_rgb_in(bg_rgb_in),
        .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .irq(irq)
    );

    always #5 clk = ~clk;

    localparam int S_RGB = 0, S_HS = 1, S_VS = 2, S_IRQ = 3, S_RD = 4;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] actual(int sel);
        case (sel)
            S_RGB:   return {10'd0, rgb_out};
            S_HS:    return {15'd0, hsync_out};
            S_VS:    return {15'd0, vsync_out};
            S_IRQ:   return {15'd0, irq};
            default: return reg_rdata;
        endcase
    endfunction

    // Monitor: compares every expectation due in the current cycle, mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if (actual(mon_e.sel) !== mon_e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", mon_e.name, actual(mon_e.sel), mon_e.exp);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int d, input int sel, input logic [15:0] v, input string n);
        sb.push_back('{cyc + d, sel, v, n});
    endtask

    task automatic chk_now(input int sel, input logic [15:0] v, input string n);
        exp_at(0, sel, v, n);
        tick();
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        reg_addr = a; reg_wdata = d; reg_we = 1'b1;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [15:0] v, input string n);
        reg_addr = a;
        chk_now(S_RD, v, n);
    endtask

    task automatic pix(input int x, input int y, input logic vis, input logic [5:0] bg,
                       input logic [5:0] v, input string n);
        pix_x = 11'(x); pix_y = 11'(y); visible = vis; bg_rgb_in = bg;
        exp_at(1, S_RGB, {10'd0, v}, n);
        tick();
    endtask

    task automatic vs_pulse;
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
    endtask

    initial begin
        // Reset with live inputs: outputs and registers must all be 0.
        visible = 1'b1; bg_rgb_in = 6'h15; hsync_in = 1'b1;
        repeat (4) tick();
        chk_now(S_RGB, 16'h0, "rst_rgb");
        chk_now(S_HS,  16'h0, "rst_hsync");
        chk_now(S_VS,  16'h0, "rst_vsync");
        chk_now(S_IRQ, 16'h0, "rst_irq");
        rd(6'h00, 16'h0, "rst_ctrl");
        rd(6'h04, 16'h0, "rst_x");
        rd(6'h0C, 16'h0, "rst_color");
        rd(6'h10, 16'h0, "rst_status");
        rd(6'h14, 16'h0, "rst_fcnt");
        rd(6'h20, 16'h0, "rst_row0");
        hsync_in = 1'b0; visible = 1'b0;
        rst_n = 1'b1;
        tick();

        // Placement: full 16x16 block at (100,50).
        wr(6'h00, 16'h0001);
        wr(6'h04, 16'd100);
        wr(6'h08, 16'd50);
        wr(6'h0C, 16'h003F);
        for (int r = 0; r < 16; r++) wr(6'(6'h20 + 2 * r), 16'hFFFF);
        rd(6'h04, 16'd100, "x_shadow_rb");
        vs_pulse();
        rd(6'h14, 16'd1, "fcnt_1");
        pix(100, 50, 1'b1, 6'h05, 6'h3F, "place_tl");
        pix(115, 65, 1'b1, 6'h05, 6'h3F, "place_br");
        pix(99,  50, 1'b1, 6'h05, 6'h05, "place_left");
        pix(116, 50, 1'b1, 6'h05, 6'h05, "place_right");
        pix(100, 49, 1'b1, 6'h05, 6'h05, "place_above");
        pix(107, 66, 1'b1, 6'h05, 6'h05, "place_below");
        pix(100, 50, 1'b0, 6'h05, 6'h00, "invisible");
        hsync_in = 1'b1;
        exp_at(1, S_HS, 16'h1, "hsync_align");
        pix(110, 55, 1'b1, 6'h05, 6'h3F, "hsync_pix");
        hsync_in = 1'b0;

        // Double buffer: shadow write mid-frame is invisible until the vsync edge.
        wr(6'h04, 16'd200);
        pix(100, 50, 1'b1, 6'h05, 6'h3F, "dbuf_old_kept");
        pix(200, 50, 1'b1, 6'h05, 6'h05, "dbuf_new_hidden");
        vsync_in = 1'b1;
        exp_at(1, S_VS, 16'h1, "vsync_align");
        tick();
        vsync_in = 1'b0;
        tick();
        rd(6'h14, 16'd2, "fcnt_2");
        pix(200, 50, 1'b1, 6'h05, 6'h3F, "dbuf_new_shown");
        pix(100, 50, 1'b1, 6'h05, 6'h05, "dbuf_old_gone");

        // IRQ: enable, W1C, re-raise on vsync, coincident W1C loses to set.
        rd(6'h10, 16'h1, "status_frame");
        wr(6'h00, 16'h0003);
        chk_now(S_IRQ, 16'h1, "irq_on_enable");
        wr(6'h10, 16'h0001);
        chk_now(S_IRQ, 16'h0, "irq_w1c");
        rd(6'h10, 16'h0, "status_cleared");
        vsync_in = 1'b1;
        exp_at(0, S_IRQ, 16'h0, "irq_pre_edge");
        exp_at(1, S_IRQ, 16'h1, "irq_rise");
        tick();
        vsync_in = 1'b0;
        tick();
        wr(6'h10, 16'h0001);
        reg_addr = 6'h10; reg_wdata = 16'h0001; reg_we = 1'b1; vsync_in = 1'b1;
        tick();
        reg_we = 1'b0; vsync_in = 1'b0;
        rd(6'h10, 16'h1, "w1c_vs_set_wins");
        rd(6'h14, 16'd4, "fcnt_4");
        wr(6'h00, 16'h0001);

        // Bit order and coordinate wrap.
        wr(6'h20, 16'h8001);
        wr(6'h04, 16'd2040);
        wr(6'h08, 16'd0);
        vs_pulse();
        pix(2040, 0, 1'b1, 6'h05, 6'h3F, "bit15_left");
        pix(2041, 0, 1'b1, 6'h05, 6'h05, "bit14_clear");
        pix(7,    0, 1'b1, 6'h05, 6'h3F, "x_wrap_bit0");
        wr(6'h04, 16'd0);
        vs_pulse();
        pix(2047, 0, 1'b1, 6'h05, 6'h05, "left_of_zero");
        pix(0,    0, 1'b1, 6'h05, 6'h3F, "x0_bit15");
        pix(15,   0, 1'b1, 6'h05, 6'h3F, "x15_bit0");
        pix(1,    0, 1'b1, 6'h05, 6'h05, "x1_bit14");
        pix(0, 2047, 1'b1, 6'h05, 6'h05, "above_zero");
        wr(6'h00, 16'h0000);
        pix(0, 0, 1'b1, 6'h05, 6'h05, "sprite_disabled");
        wr(6'h00, 16'h0001);
        wr(6'h20, 16'h0000);
        pix(0, 0, 1'b1, 6'h05, 6'h05, "bitmap_immediate");
        wr(6'h20, 16'h8000);
        wr(6'h0C, 16'h002A);
        pix(0, 0, 1'b1, 6'h05, 6'h2A, "color_immediate");
        rd(6'h20, 16'h8000, "row0_rb");
        rd(6'h3E, 16'hFFFF, "row15_rb");
        wr(6'h18, 16'hFFFF);
        rd(6'h18, 16'h0, "unmapped_rd");
        rd(6'h21, 16'h0, "odd_addr_rd");
        wr(6'h10, 16'h0003);

        // Collision.
`ifdef SPRITE_COLLISION_EN
        wr(6'h00, 16'h0005);
        pix(0, 0, 1'b1, 6'h00, 6'h2A, "coll_bg0_pix");
        rd(6'h10, 16'h0, "coll_bg0_none");
        pix(0, 0, 1'b1, 6'h01, 6'h2A, "coll_bg1_pix");
        visible = 1'b0;
        rd(6'h10, 16'h2, "coll_set");
        chk_now(S_IRQ, 16'h1, "coll_irq");
        wr(6'h10, 16'h0002);
        rd(6'h10, 16'h0, "coll_w1c");
`else
        wr(6'h00, 16'h0007);
        rd(6'h00, 16'h3, "ctrl_no_coll_bit");
        pix(0, 0, 1'b1, 6'h01, 6'h2A, "nocoll_pix");
        visible = 1'b0;
        rd(6'h10, 16'h0, "nocoll_status");
        chk_now(S_IRQ, 16'h0, "nocoll_irq");
`endif

        repeat (3) tick();
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never compared (due cycle %0d)", mon_e.name, mon_e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sprite_overlay.md
# vga_sprite_overlay

Single-sprite compositor that sits directly downstream of the background colour mux and upstream of the output PMOD. It takes the selected background RGB222 pixel plus the video timing signals, overlays one 16x16 1bpp sprite at a register-programmed position and colour, and drives the final registered RGB222, hsync and vsync. Position updates are double-buffered and committed at frame start, so a moving sprite never tears. The block raises a frame-start interrupt.

## Interface
Parameters:
- `SPR_SIZE`, default 16: sprite width and height in pixels. Fixed at 16; other values are unsupported.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `reg_addr`  in  6  register address, from the peripheral decode
- `reg_wdata`  in  16  write data
- `reg_we`  in  1  write strobe, one cycle per write
- `reg_rdata`  out  16  read data, combinational from `reg_addr`
- `pix_x`, `pix_y`  in  11 each  current pixel coordinates from the timing generator
- `visible`  in  1  active-video flag
- `hsync_in`, `vsync_in`  in  1 each  positive-polarity syncs
- `bg_rgb_in`  in  6  background pixel, {B,G,R}, 2 bits each
- `rgb_out`  out  6  composited pixel, {B,G,R}
- `hsync_out`, `vsync_out`  out  1 each  syncs delayed to align with `rgb_out`
- `irq`  out  1  level interrupt

## Operation
- Register map. Reads of unlisted addresses return 0; writes to them are ignored.
  - 0x00 CTRL[2:0]: bit0 sprite_en, bit1 frame_irq_en, bit2 coll_irq_en.
  - 0x04 X_SHADOW[10:0].
  - 0x08 Y_SHADOW[10:0].
  - 0x0C COLOR[5:0].
  - 0x10 STATUS: bit0 FRAME, bit1 COLL. Writing a 1 to a bit clears it.
  - 0x14 FRAME_CNT[15:0], read-only.
  - 0x20 + 2r, r = 0..15: bitmap row r[15:0]. Bit 15 is the leftmost pixel.
- Shadow commit: the block registers `vsync_in` and detects its rising edge. On that edge it copies X_SHADOW and Y_SHADOW into the active X and Y registers, sets STATUS.FRAME and increments FRAME_CNT.
  - FRAME_CNT is 16 bits and wraps from 0xFFFF to 0x0000.
- Bitmap and COLOR writes take effect immediately. They are not double-buffered.
- Hit test:
  - dx = pix_x − X and dy = pix_y − Y, both 11-bit modular subtraction.
  - hit when dx[10:4] == 0 and dy[10:4] == 0.
  - Coordinates left of or above the sprite therefore wrap to large values and miss.
  - The sprite clips naturally at the screen edges.
- Opaque pixel: opaque = sprite_en & visible & hit & row[dy[3:0]][15 − dx[3:0]].
- Output mux, in priority order:
  - !visible → 0.
  - opaque → COLOR.
  - otherwise → bg_rgb_in.
- IRQ: irq = (FRAME & frame_irq_en) | (COLL & coll_irq_en).
- STATUS set and clear in the same cycle: set wins.
- Reset: every register, the bitmap, active X/Y, rgb_out, hsync_out, vsync_out and irq go to 0. A reset asserted mid-frame discards any pending shadow commit.

## Timing
- Single output pipeline stage:
  - rgb_out, hsync_out and vsync_out at cycle n+1 reflect the inputs at cycle n.
  - The syncs stay aligned with the pixel.
- Register write at edge n: the value is readable at cycle n+1, and CTRL/COLOR/bitmap affect rgb_out from cycle n+2.
- Shadow commit: the active position updates on the clock edge after the cycle where vsync_in = 1 and the previous vsync_in = 0.
  - The first pixel using the new position is on the following frame's active video.
- STATUS.FRAME and irq assert one cycle after the vsync rising edge.
- A STATUS W1C clears the bit at the write edge; irq drops in the following cycle.

## Configuration
- `SPRITE_COLLISION_EN` defined:
  - STATUS.COLL sets when opaque and bg_rgb_in != 0 in the same cycle.
  - STATUS.COLL is sticky until written 1.
  - coll_irq_en gates its contribution to irq.
- Not defined: STATUS.COLL and CTRL bit2 read 0, writes to them are ignored, and no collision logic is built.

## Test plan
- Reset: hold rst_n = 0 for 4 cycles → rgb_out = 0, hsync_out = vsync_out = 0, irq = 0, every register reads 0.
- Placement: X = 100, Y = 50, all bitmap rows 0xFFFF, COLOR = 0x3F, sprite_en = 1, bg = 0x05; pulse vsync → at (100,50)…(115,65) rgb_out = 0x3F one cycle later; at (99,50) and (116,50) rgb_out = 0x05.
- Double-buffer: write X = 200 mid-frame → pixels stay at X = 100 until the vsync rising edge, then appear at X = 200; FRAME_CNT increments by 1.
- Bit order and wrap:
  - row 0 = 0x8001, X = 2040 → at pix_x = 2040 the pixel is opaque.
  - X = 0, pix_x = 2047 → the pixel is not opaque.
  - !visible → rgb_out = 0.
- IRQ: frame_irq_en = 1 → irq rises one cycle after the vsync edge; W1C STATUS = 0x1 → irq = 0; W1C coincident with a vsync edge → FRAME stays 1.
- Collision (`SPRITE_COLLISION_EN`): opaque pixel over bg = 0x00 → COLL = 0; over bg = 0x01 → COLL = 1 and irq = 1 with coll_irq_en = 1. Without the macro → STATUS reads 0x0.
